// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite memory slave: response codes, FSM state
// enums and the address range check used when decode errors are enabled.
package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_e;

   // Arguments are widened to 64 bits so one function serves any ADDR_WIDTH.
   function automatic logic addr_in_range(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] size);
      return (addr >= base) && ((addr - base) < size);
   endfunction

endpackage

// File: rtl/axil_mem_array.sv
// Word-organised storage with one byte-enabled synchronous write port and
// one registered read port; the read register is reset, the array is not.
module axil_mem_array
   import axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int IDX_WIDTH  = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [IDX_WIDTH-1:0]    waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    re,
   input  logic [IDX_WIDTH-1:0]    raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wstrb[b]) begin
               mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   // Same-edge write and read return the pre-write contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave with independent write and read FSMs.
// Define AXIL_MEM_DECERR_EN to return DECERR for addresses outside the window.
module axil_mem_slave
   import axil_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_BYTES  = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    RD_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int OFF_W  = $clog2(MEM_BYTES);
   localparam int IDX_W  = OFF_W - LSB;
   localparam int DEPTH  = MEM_BYTES / STRB_W;
   localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   wr_state_e             wr_state, wr_next;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   resp_e                 bresp_q;
   logic                  aw_hs, w_hs;
   logic                  wr_commit, wr_err, mem_we;
   logic [ADDR_WIDTH-1:0] wr_addr_sel, wr_off;
   logic [DATA_WIDTH-1:0] wr_data_sel;
   logic [STRB_W-1:0]     wr_strb_sel;

   rd_state_e             rd_state, rd_next;
   logic [CNT_W-1:0]      rd_cnt;
   logic [ADDR_WIDTH-1:0] araddr_q;
   resp_e                 rresp_q;
   logic                  rd_err_q;
   logic                  ar_hs, rd_sample, rd_err;
   logic [ADDR_WIDTH-1:0] rd_addr_sel, rd_off;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;
   assign ar_hs = arvalid & arready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state <= W_IDLE;
      end else begin
         wr_state <= wr_next;
      end
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_next = W_RESP;
            end else if (aw_hs) begin
               wr_next = W_HAVE_AW;
            end else if (w_hs) begin
               wr_next = W_HAVE_W;
            end
         end
         W_HAVE_AW: if (w_hs)   wr_next = W_RESP;
         W_HAVE_W:  if (aw_hs)  wr_next = W_RESP;
         W_RESP:    if (bready) wr_next = W_IDLE;
         default:   wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (wr_state == W_IDLE) || (wr_state == W_HAVE_W);
      wready  = (wr_state == W_IDLE) || (wr_state == W_HAVE_AW);
      bvalid  = (wr_state == W_RESP);
   end

   // Whichever half arrives last completes the pair; the other half comes
   // from its holding register.
   always_comb begin
      wr_commit   = 1'b0;
      wr_addr_sel = awaddr;
      wr_data_sel = wdata;
      wr_strb_sel = wstrb;
      case (wr_state)
         W_IDLE:    wr_commit = aw_hs & w_hs;
         W_HAVE_AW: begin
            wr_commit   = w_hs;
            wr_addr_sel = awaddr_q;
         end
         W_HAVE_W:  begin
            wr_commit   = aw_hs;
            wr_data_sel = wdata_q;
            wr_strb_sel = wstrb_q;
         end
         default: ;
      endcase
   end

`ifdef AXIL_MEM_DECERR_EN
   assign wr_err = !addr_in_range(64'(wr_addr_sel), 64'(BASE_ADDR), 64'(MEM_BYTES));
   assign rd_err = !addr_in_range(64'(rd_addr_sel), 64'(BASE_ADDR), 64'(MEM_BYTES));
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   assign mem_we = wr_commit & ~wr_err;
   assign wr_off = wr_addr_sel - BASE_ADDR;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= OKAY;
      end else begin
         if (aw_hs) begin
            awaddr_q <= awaddr;
         end
         if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (wr_commit) begin
            bresp_q <= wr_err ? DECERR : OKAY;
         end
      end
   end

   assign bresp = bresp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= R_IDLE;
      end else begin
         rd_state <= rd_next;
      end
   end

   // The counter holds the cycles still to wait; leaving R_WAIT happens on
   // the edge that would take it to zero.
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE: begin
            if (ar_hs) begin
               rd_next = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
            end
         end
         R_WAIT:  if (rd_cnt == CNT_W'(1)) rd_next = R_RESP;
         R_RESP:  if (rready)              rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready   = (rd_state == R_IDLE);
      rvalid    = (rd_state == R_RESP);
      rd_sample = (rd_state == R_IDLE) ? (ar_hs && (RD_LATENCY == 1))
                                       : ((rd_state == R_WAIT) && (rd_cnt == CNT_W'(1)));
   end

   assign rd_addr_sel = (rd_state == R_IDLE) ? araddr : araddr_q;
   assign rd_off      = rd_addr_sel - BASE_ADDR;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt   <= '0;
         araddr_q <= '0;
         rresp_q  <= OKAY;
         rd_err_q <= 1'b0;
      end else begin
         if (ar_hs) begin
            araddr_q <= araddr;
            rd_cnt   <= CNT_W'(RD_LATENCY - 1);
         end else if (rd_state == R_WAIT) begin
            rd_cnt <= rd_cnt - CNT_W'(1);
         end
         if (rd_sample) begin
            rresp_q  <= rd_err ? DECERR : OKAY;
            rd_err_q <= rd_err;
         end
      end
   end

   assign rresp = rresp_q;
   assign rdata = rd_err_q ? '0 : mem_rdata;

   // Offset bits above the window and below the word boundary are don't-care.
   logic unused_off_bits;
   assign unused_off_bits = ^{wr_off, rd_off};

   axil_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_WIDTH  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .waddr (wr_off[OFF_W-1:LSB]),
      .wdata (wr_data_sel),
      .wstrb (wr_strb_sel),
      .re    (rd_sample),
      .raddr (rd_off[OFF_W-1:LSB]),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_axil_mem_slave.sv
// Self-checking bench for axil_mem_slave: vector table, corner-case sequences
// and randomized traffic against a byte-array reference model.
module tb_axil_mem_slave;

   localparam int MEM_BYTES = 4096;
   localparam int RD_LAT    = 2;

   logic        clk;
   logic        rst_n;
   logic        awvalid, awready;
   logic [31:0] awaddr;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid, bready;
   logic [1:0]  bresp;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   int n_compared = 0;
   int n_mismatch = 0;

   logic [7:0] model_bytes [MEM_BYTES];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[$];

   axil_mem_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_BYTES  (MEM_BYTES),
      .BASE_ADDR  (32'h0),
      .RD_LATENCY (RD_LAT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .awvalid (awvalid),
      .awready (awready),
      .awaddr  (awaddr),
      .wvalid  (wvalid),
      .wready  (wready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .bvalid  (bvalid),
      .bready  (bready),
      .bresp   (bresp),
      .arvalid (arvalid),
      .arready (arready),
      .araddr  (araddr),
      .rvalid  (rvalid),
      .rready  (rready),
      .rdata   (rdata),
      .rresp   (rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic bit decerr_expected(input logic [31:0] addr);
`ifdef AXIL_MEM_DECERR_EN
      return addr >= MEM_BYTES;
`else
      return (addr > 32'hFFFF_FFFF);
`endif
   endfunction

   // Out-of-window addresses alias modulo the memory size unless decoded as errors.
   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      int base;
      if (!decerr_expected(addr)) begin
         base = int'(addr % MEM_BYTES) & ~3;
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_bytes[base + b] = data[b*8 +: 8];
         end
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      int base;
      logic [31:0] word;
      word = '0;
      if (!decerr_expected(addr)) begin
         base = int'(addr % MEM_BYTES) & ~3;
         for (int b = 0; b < 4; b++) word[b*8 +: 8] = model_bytes[base + b];
      end
      return word;
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int bdelay,
                            output logic [1:0] resp, output int bwait);
      bit aw_ok, w_ok;
      int cyc;
      @(negedge clk);
      awvalid = 1'b1; awaddr = addr;
      wvalid  = 1'b1; wdata  = data; wstrb = strb;
      aw_ok = 0; w_ok = 0; cyc = 0;
      while (!(aw_ok && w_ok) && cyc < 50) begin
         if (awvalid && awready) aw_ok = 1;
         if (wvalid && wready)   w_ok  = 1;
         @(negedge clk);
         cyc++;
         if (aw_ok) awvalid = 1'b0;
         if (w_ok)  wvalid  = 1'b0;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      checkOutput("aw_w_accepted", {aw_ok, w_ok}, 2'b11);
      bwait = 0;
      while (!bvalid && bwait < 50) begin
         @(negedge clk);
         bwait++;
      end
      checkOutput("bvalid_seen", bvalid, 1);
      repeat (bdelay) begin
         @(negedge clk);
         checkOutput("bvalid_hold", bvalid, 1);
      end
      resp  = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      model_write(addr, data, strb);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int rdelay,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
      int cyc;
      @(negedge clk);
      arvalid = 1'b1; araddr = addr; cyc = 0;
      while (!arready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("arready_seen", arready, 1);
      @(negedge clk);
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("rvalid_seen", rvalid, 1);
      repeat (rdelay) begin
         @(negedge clk);
         checkOutput("rvalid_hold", rvalid, 1);
      end
      data = rdata; resp = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      logic [1:0]  resp;
      logic [31:0] data;
      int          lat;
      if (v.wr) begin
         axi_write(v.addr, v.data, v.strb, 0, resp, lat);
         checkOutput($sformatf("vec%0d_bresp", idx), resp, v.exp_resp);
         checkOutput($sformatf("vec%0d_bvalid_latency", idx), lat, 0);
      end else begin
         axi_read(v.addr, 0, data, resp, lat);
         checkOutput($sformatf("vec%0d_rdata", idx), data, v.exp_data);
         checkOutput($sformatf("vec%0d_rresp", idx), resp, v.exp_resp);
         checkOutput($sformatf("vec%0d_rd_latency", idx), lat, RD_LAT);
      end
   endtask

   task automatic check_idle(input string tag);
      checkOutput({tag, "_bvalid"},  bvalid,  0);
      checkOutput({tag, "_rvalid"},  rvalid,  0);
      checkOutput({tag, "_awready"}, awready, 1);
      checkOutput({tag, "_wready"},  wready,  1);
      checkOutput({tag, "_arready"}, arready, 1);
   endtask

   initial begin
      logic [31:0] rd_val, addr, data;
      logic [1:0]  resp;
      logic [3:0]  strb;
      int          lat;
      logic [1:0]  oor_resp;
      logic [31:0] oor_rdata, word0_after;

      rst_n = 1'b0;
      awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0;
      bready = 0; arvalid = 0; araddr = '0; rready = 0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      checkOutput("reset_bresp", bresp, 0);
      checkOutput("reset_rresp", rresp, 0);
      checkOutput("reset_rdata", rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef AXIL_MEM_DECERR_EN
      oor_resp = 2'b11; oor_rdata = 32'h0; word0_after = 32'h01020304;
`else
      oor_resp = 2'b00; oor_rdata = 32'hCAFEF00D; word0_after = 32'hCAFEF00D;
`endif

      vecs.push_back('{wr:1, addr:32'h10,   data:32'hDEADBEEF, strb:4'hF, exp_data:'0,           exp_resp:2'b00});
      vecs.push_back('{wr:0, addr:32'h10,   data:'0,           strb:4'h0, exp_data:32'hDEADBEEF, exp_resp:2'b00});
      vecs.push_back('{wr:1, addr:32'h30,   data:32'hAABBCCDD, strb:4'hF, exp_data:'0,           exp_resp:2'b00});
      vecs.push_back('{wr:1, addr:32'h30,   data:32'h00000055, strb:4'h1, exp_data:'0,           exp_resp:2'b00});
      vecs.push_back('{wr:0, addr:32'h30,   data:'0,           strb:4'h0, exp_data:32'hAABBCC55, exp_resp:2'b00});
      vecs.push_back('{wr:1, addr:32'h32,   data:32'hFFFFFFFF, strb:4'h0, exp_data:'0,           exp_resp:2'b00});
      vecs.push_back('{wr:0, addr:32'h33,   data:'0,           strb:4'h0, exp_data:32'hAABBCC55, exp_resp:2'b00});
      vecs.push_back('{wr:1, addr:32'h40,   data:32'h00000000, strb:4'hF, exp_data:'0,           exp_resp:2'b00});
      vecs.push_back('{wr:1, addr:32'h41,   data:32'h12345678, strb:4'hA, exp_data:'0,           exp_resp:2'b00});
      vecs.push_back('{wr:0, addr:32'h40,   data:'0,           strb:4'h0, exp_data:32'h12005600, exp_resp:2'b00});
      vecs.push_back('{wr:1, addr:32'h0,    data:32'h01020304, strb:4'hF, exp_data:'0,           exp_resp:2'b00});
      vecs.push_back('{wr:1, addr:32'h2000, data:32'hCAFEF00D, strb:4'hF, exp_data:'0,           exp_resp:oor_resp});
      vecs.push_back('{wr:0, addr:32'h2000, data:'0,           strb:4'h0, exp_data:oor_rdata,    exp_resp:oor_resp});
      vecs.push_back('{wr:0, addr:32'h0,    data:'0,           strb:4'h0, exp_data:word0_after,  exp_resp:2'b00});
      vecs.push_back('{wr:0, addr:32'h1010, data:'0,           strb:4'h0, exp_data:(oor_resp == 2'b11) ? 32'h0 : 32'hDEADBEEF, exp_resp:oor_resp});

      for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

      // W arrives well before AW; the pair completes on the AW handshake.
      @(negedge clk);
      wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF;
      checkOutput("early_w_wready_idle", wready, 1);
      @(negedge clk);
      wvalid = 1'b0;
      repeat (3) begin
         checkOutput("early_w_wready_low", wready, 0);
         checkOutput("early_w_awready", awready, 1);
         checkOutput("early_w_no_bvalid", bvalid, 0);
         @(negedge clk);
      end
      awvalid = 1'b1; awaddr = 32'h20;
      @(negedge clk);
      awvalid = 1'b0;
      checkOutput("early_w_bvalid_next", bvalid, 1);
      checkOutput("early_w_bresp", bresp, 0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      model_write(32'h20, 32'h11223344, 4'hF);
      axi_read(32'h20, 0, rd_val, resp, lat);
      checkOutput("early_w_readback", rd_val, 32'h11223344);

      // Response back-pressure on both channels.
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h60; wvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (5) begin
         checkOutput("bstall_bvalid", bvalid, 1);
         checkOutput("bstall_bresp", bresp, 0);
         checkOutput("bstall_awready", awready, 0);
         checkOutput("bstall_wready", wready, 0);
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      checkOutput("bstall_release_bvalid", bvalid, 0);
      checkOutput("bstall_release_awready", awready, 1);
      model_write(32'h60, 32'h5A5A5A5A, 4'hF);

      arvalid = 1'b1; araddr = 32'h60;
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      repeat (5) begin
         checkOutput("rstall_rvalid", rvalid, 1);
         checkOutput("rstall_rdata", rdata, 32'h5A5A5A5A);
         checkOutput("rstall_rresp", rresp, 0);
         checkOutput("rstall_arready", arready, 0);
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checkOutput("rstall_release_rvalid", rvalid, 0);
      checkOutput("rstall_release_arready", arready, 1);

      // A write committing on the read's sampling edge must not be seen.
      axi_write(32'h50, 32'h11111111, 4'hF, 0, resp, lat);
      @(negedge clk);
      arvalid = 1'b1; araddr = 32'h50;
      @(negedge clk);
      arvalid = 1'b0;
      awvalid = 1'b1; awaddr = 32'h50; wvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      checkOutput("collide_bvalid", bvalid, 1);
      checkOutput("collide_rvalid", rvalid, 1);
      checkOutput("collide_old_data", rdata, 32'h11111111);
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      model_write(32'h50, 32'h22222222, 4'hF);
      axi_read(32'h50, 0, rd_val, resp, lat);
      checkOutput("collide_new_data", rd_val, 32'h22222222);

      // Reset while a read is waiting for its data.
      @(negedge clk);
      arvalid = 1'b1; araddr = 32'h10;
      @(negedge clk);
      arvalid = 1'b0;
      checkOutput("rwait_arready_low", arready, 0);
      rst_n = 1'b0;
      #1;
      check_idle("rwait_reset");
      checkOutput("rwait_reset_rdata", rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("rwait_after_rvalid", rvalid, 0);
      end

      // Reset after AW only; the write must never reach memory.
      awvalid = 1'b1; awaddr = 32'h10;
      @(negedge clk);
      awvalid = 1'b0;
      checkOutput("haveaw_awready_low", awready, 0);
      checkOutput("haveaw_wready_high", wready, 1);
      wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
      rst_n = 1'b0;
      #1;
      check_idle("haveaw_reset");
      @(negedge clk);
      wvalid = 1'b0;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("haveaw_after_bvalid", bvalid, 0);
      end
      axi_read(32'h10, 0, rd_val, resp, lat);
      checkOutput("haveaw_word_unchanged", rd_val, 32'hDEADBEEF);

      // Randomized traffic over 16 words plus their alias window.
      for (int w = 0; w < 16; w++) begin
         axi_write(32'(w * 4), $urandom, 4'hF, 0, resp, lat);
      end
      for (int n = 0; n < 300; n++) begin
         addr = 32'($urandom_range(0, 1) * 32'h1000 + $urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            axi_write(addr, data, strb, $urandom_range(0, 2), resp, lat);
            checkOutput($sformatf("rand%0d_bresp", n), resp,
                        decerr_expected(addr) ? 2'b11 : 2'b00);
            checkOutput($sformatf("rand%0d_blat", n), lat, 0);
         end else begin
            axi_read(addr, $urandom_range(0, 2), rd_val, resp, lat);
            checkOutput($sformatf("rand%0d_rdata@%0h", n, addr), rd_val, model_read(addr));
            checkOutput($sformatf("rand%0d_rresp", n), resp,
                        decerr_expected(addr) ? 2'b11 : 2'b00);
            checkOutput($sformatf("rand%0d_rlat", n), lat, RD_LAT);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule

// File: doc/axil_mem_slave.md
AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH 32: address bits; DATA_WIDTH 32: data bits, 32 or 64; MEM_BYTES 4096: memory size, power of 2; BASE_ADDR 0: first mapped byte address, MEM_BYTES-aligned; RD_LATENCY 2: cycles from AR handshake to rvalid, >=1.
REQ-002 Clocking SHALL be: clk input 1 clock; rst_n input 1, asynchronous, active-low reset.
REQ-003 Write address ports SHALL be: awvalid in 1; awready out 1; awaddr in ADDR_WIDTH.
REQ-004 Write data ports SHALL be: wvalid in 1; wready out 1; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8.
REQ-005 Write response ports SHALL be: bvalid out 1; bready in 1; bresp out 2.
REQ-006 Read address ports SHALL be: arvalid in 1; arready out 1; araddr in ADDR_WIDTH.
REQ-007 Read data ports SHALL be: rvalid out 1; rready in 1; rdata out DATA_WIDTH; rresp out 2.

Function
REQ-008 Write FSM states SHALL be W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP; read FSM states SHALL be R_IDLE, R_WAIT, R_RESP; the two FSMs SHALL run independently.
REQ-009 awready SHALL be 1 in W_IDLE and W_HAVE_W only; wready SHALL be 1 in W_IDLE and W_HAVE_AW only.
REQ-010 From W_IDLE: AW-only handshake -> W_HAVE_AW (awaddr latched); W-only handshake -> W_HAVE_W (wdata/wstrb latched); both in same cycle -> W_RESP.
REQ-011 The memory write SHALL commit on the edge completing the AW/W pair; bvalid SHALL rise on the following cycle (one-cycle write latency).
REQ-012 Only bytes whose wstrb bit is 1 SHALL be updated; wstrb=0 SHALL leave memory unchanged and still return OKAY.
REQ-013 bvalid, bresp SHALL hold stable until bready; the bvalid&bready edge SHALL return to W_IDLE; no new AW/W SHALL be accepted in W_RESP.
REQ-014 arready SHALL be 1 in R_IDLE only; the AR handshake latches araddr and loads a down-counter with RD_LATENCY-1.
REQ-015 RD_LATENCY=1 SHALL go R_IDLE->R_RESP directly; otherwise R_WAIT decrements each cycle and exits to R_RESP at 0, so rvalid rises exactly RD_LATENCY cycles after the AR handshake.
REQ-016 rdata SHALL be sampled from memory on the edge entering R_RESP and held with rresp until rvalid&rready, then R_IDLE.
REQ-017 A write committing on the same edge the read samples SHALL NOT be visible (old data returned); a write committed on any earlier edge SHALL be visible.
REQ-018 Address low log2(DATA_WIDTH/8) bits SHALL be ignored; word index = (addr-BASE_ADDR)[log2(MEM_BYTES)-1 : log2(DATA_WIDTH/8)].
REQ-019 bresp and rresp SHALL be OKAY (2'b00) except as REQ-023 states.

Reset
REQ-020 rst_n low SHALL force W_IDLE, R_IDLE, counter 0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, awready=1, wready=1, arready=1.
REQ-021 Reset mid-transaction SHALL abandon the transaction without a response; a write not yet committed SHALL NOT reach memory.
REQ-022 Memory contents SHALL NOT be reset.

Configuration
REQ-023 With AXIL_MEM_DECERR_EN defined, addresses outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) SHALL return DECERR (2'b11), writes SHALL NOT modify memory, reads SHALL return rdata=0.
REQ-024 Without AXIL_MEM_DECERR_EN, out-of-range addresses SHALL alias modulo MEM_BYTES with OKAY.

Structure
REQ-025 Package axil_pkg SHALL hold resp_e (OKAY, EXOKAY, SLVERR, DECERR), the write and read state enums, and the range-check function.
REQ-026 Storage SHALL be sub-module axil_mem_array: one byte-enabled synchronous write port, one synchronous read port, DATA_WIDTH wide, MEM_BYTES/(DATA_WIDTH/8) deep.

Verification
REQ-027 AW 0x10 and W 0xDEADBEEF, strb 0xF same cycle -> bvalid next cycle, bresp 0; AR 0x10 -> rvalid 2 cycles later, rdata 0xDEADBEEF.
REQ-028 W 0x11223344 three cycles before AW 0x20 -> wready low until AW; bvalid one cycle after AW handshake; read 0x20 returns 0x11223344.
REQ-029 Word 0x30=0xAABBCCDD, write 0x00000055 strb 0x1 -> read returns 0xAABBCC55.
REQ-030 bready held low 5 cycles -> bvalid/bresp stable, awready/wready low throughout; rready low 5 cycles -> rvalid/rdata stable, arready low.
REQ-031 With AXIL_MEM_DECERR_EN, write then read 0x2000 (MEM_BYTES 4096) -> bresp 2'b11, rresp 2'b11, rdata 0, word 0 unchanged; without it -> OKAY, aliases word 0.
REQ-032 rst_n pulsed low during R_WAIT and W_HAVE_AW -> no rvalid/bvalid, all readies 1, target word unchanged.
